eth_rx_frame_parser: RTL and testbench
======================================

ETH_RX_FRAME_PARSER -- requirements
Module: eth_rx_frame_parser

Interface
REQ-001 SHALL have parameter C_TYPE_FILTER_EN, default 0: 1 = only frames whose EtherType equals C_TYPE_VALUE are forwarded.
REQ-002 SHALL have parameter C_TYPE_VALUE, default 16'h0800: EtherType accepted when filtering is enabled.
REQ-003 rx_mac_aclk  input  1  receive MAC clock; the only clock, all logic on its rising edge.
REQ-004 rx_mac_reset  input  1  asynchronous, active-high reset.
REQ-005 s_axis_tdata  input  8  frame byte from the MAC, destination MAC first; no tready, the source cannot stall.
REQ-006 s_axis_tvalid  input  1  byte qualifier; gaps of any length allowed.
REQ-007 s_axis_tlast  input  1  last byte of the frame.
REQ-008 s_axis_tuser  input  1  frame error (FCS/RX error); meaningful only with tlast.
REQ-009 hdr_valid  output  1  one-cycle pulse: the header fields are updated for an accepted frame.
REQ-010 hdr_dst_mac  output  48  destination MAC, byte 0 in bits [47:40].
REQ-011 hdr_src_mac  output  48  source MAC, byte 6 in bits [47:40].
REQ-012 hdr_ethertype  output  16  bytes 12 and 13, with byte 12 in [15:8].
REQ-013 m_axis_tdata / m_axis_tvalid / m_axis_tlast / m_axis_tuser  output  8/1/1/1  payload stream (bytes 14 onward).
REQ-014 runt_err  output  1  one-cycle pulse: the frame ended before any payload byte.
REQ-015 frame_cnt  output  16  count of good forwarded frames.
REQ-016 drop_cnt  output  16  count of runt, type-rejected, and errored frames.

Function
REQ-017 SHALL implement states S_HDR, S_PAYLOAD and S_DROP; a 4-bit byte index advances only on s_axis_tvalid.
REQ-018 In S_HDR, SHALL capture bytes 0-5 into hdr_dst_mac, bytes 6-11 into hdr_src_mac, and bytes 12-13 into hdr_ethertype, writing into shadow registers.
REQ-019 On byte 13 without tlast, SHALL apply the type check: it passes if C_TYPE_FILTER_EN=0 or the EtherType equals C_TYPE_VALUE.
  - Pass: copy shadow registers to the outputs, pulse hdr_valid on the next cycle, go to S_PAYLOAD.
  - Fail: go to S_DROP with no hdr_valid; output header fields keep their prior values.
REQ-020 A valid byte with tlast=1 at index 0..13 in S_HDR (runt) SHALL:
  - pulse runt_err on the next cycle;
  - increment drop_cnt;
  - produce no hdr_valid and no payload;
  - clear the index and remain in S_HDR.
REQ-021 In S_PAYLOAD, each valid input byte SHALL appear on m_axis_* exactly 1 cycle later, with tdata, tlast and tuser registered; m_axis_tvalid is high only for those cycles.
REQ-022 m_axis_tuser SHALL equal s_axis_tuser when m_axis_tlast=1, and 0 otherwise.
REQ-023 A tlast in S_PAYLOAD SHALL return the block to S_HDR with index 0 and update the counters:
  - tuser=0: increment frame_cnt;
  - tuser=1: increment drop_cnt.
  The errored frame is still forwarded, with m_axis_tuser=1.
REQ-024 In S_DROP, bytes SHALL be consumed with no output; a tlast SHALL increment drop_cnt and return the block to S_HDR.
REQ-025 frame_cnt and drop_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-026 The first byte of a new frame SHALL be accepted in the cycle immediately after the previous tlast, with zero dead cycles.
REQ-027 A frame with exactly 15 bytes SHALL yield one payload beat, with m_axis_tvalid=1 and m_axis_tlast=1.

Reset
REQ-028 While rx_mac_reset=1, SHALL hold:
  - state S_HDR with index 0;
  - all outputs at 0: header fields, counters, m_axis_*, hdr_valid, runt_err.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with no tlast emitted and no counter update.
REQ-030 After reset deasserts, the next valid byte SHALL be treated as byte 0.

Verification
REQ-031 Defaults; send 20-byte frame (dst 01:02:03:04:05:06, src 0A:0B:0C:0D:0E:0F, type 0800, payload 5A..5F) -> expected response:
  - hdr_valid pulses once with all three fields correct;
  - 6 payload beats 5A..5F, each 1 cycle after input, tlast on 5F;
  - frame_cnt=1.
REQ-032 C_TYPE_FILTER_EN=1, C_TYPE_VALUE=0800; send frame with type 0806 -> expected response:
  - no hdr_valid and no m_axis_tvalid;
  - drop_cnt=1;
  - the following 0800 frame is forwarded normally.
REQ-033 Send a 10-byte frame, then a 14-byte frame -> expected response:
  - runt_err pulses twice and drop_cnt=2;
  - no payload and no hdr_valid.
REQ-034 20-byte frame with tuser=1 on tlast -> expected response: payload forwarded, last beat has m_axis_tuser=1, drop_cnt=1, frame_cnt=0.
REQ-035 Stream a 15-byte frame with random tvalid gaps, then back-to-back frames with no idle cycle -> expected response: each frame parsed independently and each frame yields the correct payload beats; for the 15-byte frame, exactly one beat with tlast=1.
REQ-036 Assert reset during payload byte 3 of a frame, then send a clean frame -> expected response:
  - all outputs are 0 during reset;
  - the clean frame is parsed from byte 0;
  - frame_cnt=1.

Source files
------------

// File: rtl/eth_rx_frame_parser.sv
// Ethernet receive header parser: captures dst/src MAC and EtherType, optionally filters
// on EtherType, forwards the payload with one cycle of latency and counts good/dropped frames.
module eth_rx_frame_parser #(
   parameter bit          C_TYPE_FILTER_EN = 1'b0,
   parameter logic [15:0] C_TYPE_VALUE     = 16'h0800
) (
   input  logic        rx_mac_aclk,
   input  logic        rx_mac_reset,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tuser,
   output logic        hdr_valid,
   output logic [47:0] hdr_dst_mac,
   output logic [47:0] hdr_src_mac,
   output logic [15:0] hdr_ethertype,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic        runt_err,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
);

   localparam int unsigned IDX_W    = 4;
   localparam int unsigned LAST_HDR = 13;

   typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DROP} state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [47:0]        dst_sh;
   logic [47:0]        src_sh;
   logic [7:0]         type_hi_sh;
   logic [15:0]        type_c;
   logic               type_ok_c;

   // Byte 13 is checked in flight, so the EtherType is assembled from the shadow and the live byte.
   assign type_c    = {type_hi_sh, s_axis_tdata};
   assign type_ok_c = !C_TYPE_FILTER_EN || (type_c == C_TYPE_VALUE);

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge rx_mac_aclk or posedge rx_mac_reset) begin
      if (rx_mac_reset) begin
         state         <= S_HDR;
         idx           <= '0;
         dst_sh        <= '0;
         src_sh        <= '0;
         type_hi_sh    <= '0;
         hdr_valid     <= 1'b0;
         hdr_dst_mac   <= '0;
         hdr_src_mac   <= '0;
         hdr_ethertype <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         runt_err      <= 1'b0;
         frame_cnt     <= '0;
         drop_cnt      <= '0;
      end else begin
         hdr_valid     <= 1'b0;
         runt_err      <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         if (s_axis_tvalid) begin
            case (state)
               S_HDR: begin
                  if (s_axis_tlast) begin
                     runt_err <= 1'b1;
                     drop_cnt <= sat_inc(drop_cnt);
                     idx      <= '0;
                  end else if (idx == IDX_W'(LAST_HDR)) begin
                     idx <= '0;
                     if (type_ok_c) begin
                        hdr_dst_mac   <= dst_sh;
                        hdr_src_mac   <= src_sh;
                        hdr_ethertype <= type_c;
                        hdr_valid     <= 1'b1;
                        state         <= S_PAYLOAD;
                     end else begin
                        state <= S_DROP;
                     end
                  end else begin
                     // Shifting in MSB-first leaves byte 0 / byte 6 in bits [47:40].
                     if (idx < IDX_W'(6))
                        dst_sh <= {dst_sh[39:0], s_axis_tdata};
                     else if (idx < IDX_W'(12))
                        src_sh <= {src_sh[39:0], s_axis_tdata};
                     else
                        type_hi_sh <= s_axis_tdata;
                     idx <= idx + IDX_W'(1);
                  end
               end
               S_PAYLOAD: begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= s_axis_tdata;
                  m_axis_tlast  <= s_axis_tlast;
                  m_axis_tuser  <= s_axis_tlast & s_axis_tuser;
                  if (s_axis_tlast) begin
                     state <= S_HDR;
                     idx   <= '0;
                     if (s_axis_tuser)
                        drop_cnt <= sat_inc(drop_cnt);
                     else
                        frame_cnt <= sat_inc(frame_cnt);
                  end
               end
               S_DROP: begin
                  if (s_axis_tlast) begin
                     state    <= S_HDR;
                     idx      <= '0;
                     drop_cnt <= sat_inc(drop_cnt);
                  end
               end
               default: begin
                  state <= S_HDR;
                  idx   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Directed bench for eth_rx_frame_parser: one default instance and one EtherType-filtering
// instance share the same input stream.
module tb_eth_rx_frame_parser;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;

   logic        d_hv, d_mvalid, d_mlast, d_muser, d_runt;
   logic [47:0] d_dst, d_src;
   logic [15:0] d_type, d_frame, d_drop;
   logic [7:0]  d_mdata;
   logic        f_hv, f_mvalid, f_mlast, f_muser, f_runt;
   logic [47:0] f_dst, f_src;
   logic [15:0] f_type, f_frame, f_drop;
   logic [7:0]  f_mdata;

   eth_rx_frame_parser u_def (
      .rx_mac_aclk(clk), .rx_mac_reset(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .hdr_valid(d_hv), .hdr_dst_mac(d_dst), .hdr_src_mac(d_src), .hdr_ethertype(d_type),
      .m_axis_tdata(d_mdata), .m_axis_tvalid(d_mvalid), .m_axis_tlast(d_mlast), .m_axis_tuser(d_muser),
      .runt_err(d_runt), .frame_cnt(d_frame), .drop_cnt(d_drop)
   );

   eth_rx_frame_parser #(.C_TYPE_FILTER_EN(1'b1), .C_TYPE_VALUE(16'h0800)) u_flt (
      .rx_mac_aclk(clk), .rx_mac_reset(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .hdr_valid(f_hv), .hdr_dst_mac(f_dst), .hdr_src_mac(f_src), .hdr_ethertype(f_type),
      .m_axis_tdata(f_mdata), .m_axis_tvalid(f_mvalid), .m_axis_tlast(f_mlast), .m_axis_tuser(f_muser),
      .runt_err(f_runt), .frame_cnt(f_frame), .drop_cnt(f_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic       u;
      int         c;
   } beat_t;

   int    cyc = 0;
   int    n_cmp = 0;
   int    n_bad = 0;
   int    d_hv_n = 0, d_runt_n = 0, f_hv_n = 0, f_beat_n = 0;
   beat_t obs[$];
   beat_t exp_q[$];
   logic [7:0] fb[$];

   always @(posedge clk) cyc++;

   // Outputs are sampled on the falling edge, away from the register updates.
   always @(negedge clk) begin
      if (d_mvalid) obs.push_back('{d_mdata, d_mlast, d_muser, cyc});
      if (d_hv)     d_hv_n++;
      if (d_runt)   d_runt_n++;
      if (f_hv)     f_hv_n++;
      if (f_mvalid) f_beat_n++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic drive(input logic [7:0] d, input logic l, input logic u, input logic v);
      @(negedge clk);
      s_tdata  = d;
      s_tlast  = l;
      s_tuser  = u;
      s_tvalid = v;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                        input logic [7:0] p0, input int npay);
      fb.delete();
      for (int i = 0; i < 6; i++) fb.push_back(dst[8*(5-i) +: 8]);
      for (int i = 0; i < 6; i++) fb.push_back(src[8*(5-i) +: 8]);
      fb.push_back(et[15:8]);
      fb.push_back(et[7:0]);
      for (int i = 0; i < npay; i++) fb.push_back(8'(int'(p0) + i));
   endtask

   // tuser is driven on every byte so a leak onto non-last payload beats shows up.
   task automatic send_frame(input logic user, input int gap_max, input bit fwd);
      logic last;
      int   g;
      for (int i = 0; i < fb.size(); i++) begin
         last = (i == fb.size() - 1);
         if (gap_max > 0) begin
            g = $urandom_range(gap_max, 0);
            repeat (g) drive(8'hEE, 1'b1, 1'b1, 1'b0);
         end
         drive(fb[i], last, user, 1'b1);
         if (fwd && i >= 14) exp_q.push_back('{fb[i], last, last & user, cyc + 1});
      end
   endtask

   task automatic cmp_beats(input string tag);
      int n;
      chk({tag, "_beat_count"}, 64'(obs.size()), 64'(exp_q.size()));
      n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_beat%0d_data_last_user", tag, i),
             64'({obs[i].d, obs[i].l, obs[i].u}), 64'({exp_q[i].d, exp_q[i].l, exp_q[i].u}));
         chk($sformatf("%s_beat%0d_cycle", tag, i), 64'(obs[i].c), 64'(exp_q[i].c));
      end
      obs.delete();
      exp_q.delete();
   endtask

   task automatic check_rst(input string tag);
      chk({tag, "_hdr_valid"}, 64'(d_hv), 64'd0);
      chk({tag, "_dst"}, 64'(d_dst), 64'd0);
      chk({tag, "_src"}, 64'(d_src), 64'd0);
      chk({tag, "_type"}, 64'(d_type), 64'd0);
      chk({tag, "_m_axis"}, 64'({d_mdata, d_mvalid, d_mlast, d_muser}), 64'd0);
      chk({tag, "_runt"}, 64'(d_runt), 64'd0);
      chk({tag, "_cnts"}, 64'({d_frame, d_drop}), 64'd0);
      chk({tag, "_flt_outs"}, 64'({f_hv, f_mvalid, f_frame, f_drop}), 64'd0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst      = 1'b1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
      s_tdata  = 8'h00;
      #1;
      check_rst(tag);
      @(negedge clk);
      obs.delete();
      exp_q.delete();
      d_hv_n = 0; d_runt_n = 0; f_hv_n = 0; f_beat_n = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   localparam logic [47:0] DST1 = 48'h010203040506;
   localparam logic [47:0] SRC1 = 48'h0A0B0C0D0E0F;
   localparam logic [47:0] DST2 = 48'h112233445566;
   localparam logic [47:0] SRC2 = 48'hAABBCCDDEEFF;

   initial begin
      do_reset("por");

      // Basic 20-byte frame with defaults
      build(DST1, SRC1, 16'h0800, 8'h5A, 6);
      send_frame(1'b0, 0, 1'b1);
      idle(3);
      chk("t1_hdr_valid_pulses", 64'(d_hv_n), 64'd1);
      chk("t1_dst", 64'(d_dst), 64'(DST1));
      chk("t1_src", 64'(d_src), 64'(SRC1));
      chk("t1_type", 64'(d_type), 64'h0800);
      cmp_beats("t1");
      chk("t1_frame_cnt", 64'(d_frame), 64'd1);
      chk("t1_drop_cnt", 64'(d_drop), 64'd0);

      // EtherType filter: 0806 dropped, 0800 forwarded
      do_reset("t2_rst");
      build(DST1, SRC1, 16'h0806, 8'h5A, 6);
      send_frame(1'b0, 0, 1'b1);
      idle(2);
      chk("t2_flt_no_hdr_valid", 64'(f_hv_n), 64'd0);
      chk("t2_flt_no_beats", 64'(f_beat_n), 64'd0);
      chk("t2_flt_drop_cnt", 64'(f_drop), 64'd1);
      chk("t2_flt_type_kept", 64'(f_type), 64'd0);
      chk("t2_def_type", 64'(d_type), 64'h0806);
      build(DST1, SRC1, 16'h0800, 8'h5A, 6);
      send_frame(1'b0, 0, 1'b1);
      idle(2);
      chk("t2_flt_hdr_valid", 64'(f_hv_n), 64'd1);
      chk("t2_flt_beats", 64'(f_beat_n), 64'd6);
      chk("t2_flt_cnts", 64'({f_frame, f_drop}), 64'({16'd1, 16'd1}));
      chk("t2_flt_type", 64'(f_type), 64'h0800);
      cmp_beats("t2_def");

      // Runts: 10 bytes, then 14 bytes, then a good frame
      do_reset("t3_rst");
      build(DST1, SRC1, 16'h0800, 8'h00, 0);
      repeat (4) void'(fb.pop_back());
      send_frame(1'b0, 0, 1'b0);
      build(DST1, SRC1, 16'h0800, 8'h00, 0);
      send_frame(1'b0, 0, 1'b0);
      idle(2);
      chk("t3_runt_pulses", 64'(d_runt_n), 64'd2);
      chk("t3_drop_cnt", 64'(d_drop), 64'd2);
      chk("t3_no_hdr_valid", 64'(d_hv_n), 64'd0);
      chk("t3_dst_kept", 64'(d_dst), 64'd0);
      cmp_beats("t3_runt");
      build(DST2, SRC2, 16'h0800, 8'hC0, 3);
      send_frame(1'b0, 0, 1'b1);
      idle(2);
      chk("t3_after_frame_cnt", 64'(d_frame), 64'd1);
      chk("t3_after_dst", 64'(d_dst), 64'(DST2));
      cmp_beats("t3_after");

      // Errored frame is forwarded but counted as a drop
      do_reset("t4_rst");
      build(DST1, SRC1, 16'h0800, 8'h5A, 6);
      send_frame(1'b1, 0, 1'b1);
      idle(2);
      cmp_beats("t4");
      chk("t4_cnts", 64'({d_frame, d_drop}), 64'({16'd0, 16'd1}));
      chk("t4_hdr_valid", 64'(d_hv_n), 64'd1);

      // 15-byte frame with gaps, then back-to-back frames
      do_reset("t5_rst");
      build(DST1, SRC1, 16'h0800, 8'h77, 1);
      send_frame(1'b0, 3, 1'b1);
      build(DST1, SRC1, 16'h0800, 8'h88, 1);
      send_frame(1'b0, 0, 1'b1);
      build(DST2, SRC2, 16'h88B5, 8'h30, 6);
      send_frame(1'b0, 0, 1'b1);
      idle(2);
      cmp_beats("t5");
      chk("t5_frame_cnt", 64'(d_frame), 64'd3);
      chk("t5_hdr_valid", 64'(d_hv_n), 64'd3);
      chk("t5_dst", 64'(d_dst), 64'(DST2));
      chk("t5_src", 64'(d_src), 64'(SRC2));
      chk("t5_type", 64'(d_type), 64'h88B5);

      // Reset during payload byte 3, then a clean frame
      do_reset("t6_pre");
      build(DST1, SRC1, 16'h0800, 8'h5A, 6);
      for (int i = 0; i < 17; i++) drive(fb[i], 1'b0, 1'b0, 1'b1);
      do_reset("t6_mid");
      build(DST2, SRC1, 16'h0800, 8'h40, 4);
      send_frame(1'b0, 0, 1'b1);
      idle(2);
      cmp_beats("t6");
      chk("t6_cnts", 64'({d_frame, d_drop}), 64'({16'd1, 16'd0}));
      chk("t6_dst", 64'(d_dst), 64'(DST2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
